// File: rtl/bitserial_addsub.sv
// Bit-serial add/subtract unit: one full-adder/subtractor slice with a
// registered carry/borrow, processing N-bit operands LSB-first under start/done.
module bitserial_addsub #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op,
    input  logic [N-1:0] d_in,
    input  logic [N-1:0] y_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] x_out,
    output logic         cout
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  r_q, r_d;
    logic [N-1:0]  x_q, x_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          opr_q, opr_d;
    logic          c_q, c_d;
    logic          cout_q, cout_d;

    logic          sum_bit;
    logic          c_next;
    logic [N-1:0]  r_shifted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            x_q     <= '0;
            cnt_q   <= '0;
            opr_q   <= 1'b0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            opr_q   <= opr_d;
            c_q     <= c_d;
            cout_q  <= cout_d;
        end
    end

    // Carry for ADD, borrow for SUB; the sum/difference bit is the same XOR.
    always_comb begin
        sum_bit   = a_q[0] ^ b_q[0] ^ c_q;
        if (opr_q)
            c_next = (~a_q[0] & b_q[0]) | (c_q & ~(a_q[0] ^ b_q[0]));
        else
            c_next = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
        r_shifted = {sum_bit, r_q[N-1:1]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        opr_d   = opr_q;
        c_d     = c_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = d_in;
                    b_d     = y_in;
                    opr_d   = op;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    r_d     = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                r_d   = r_shifted;
                c_d   = c_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    x_d     = r_shifted;
                    cout_d  = c_next;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy  = (state_q == SHIFT);
    assign done  = (state_q == DONE);
    assign x_out = x_q;
    assign cout  = cout_q;

endmodule

// File: tb/tb_bitserial_addsub.sv
// Testbench for bitserial_addsub: directed table, exhaustive and random sweeps
// against an arithmetic model, continuous-start and async-reset sequences.
module tb_bitserial_addsub;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [N-1:0] d_in = '0;
    logic [N-1:0] y_in = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] x_out;
    logic         cout;

    int testsRun = 0;
    int testsFailed = 0;

    logic [N-1:0] lastX = '0;
    logic         lastC = 1'b0;

    bitserial_addsub #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .d_in  (d_in),
        .y_in  (y_in),
        .busy  (busy),
        .done  (done),
        .x_out (x_out),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         op;
        logic [N-1:0] d;
        logic [N-1:0] y;
        logic [N-1:0] ex;
        logic         ec;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Golden arithmetic: plain integer add/subtract modulo 2^N.
    function automatic void model(input logic o, input logic [N-1:0] d, input logic [N-1:0] y,
                                  output logic [N-1:0] ex, output logic ec);
        int r;
        if (o) begin
            r  = int'(d) - int'(y);
            ec = (d < y);
        end else begin
            r  = int'(d) + int'(y);
            ec = (r >= (1 << N));
        end
        ex = r[N-1:0];
    endfunction

    task automatic runOp(input logic o, input logic [N-1:0] d, input logic [N-1:0] y,
                         output logic [N-1:0] gx, output logic gc,
                         output int lat, output int busyN, output bit holdOk);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        d_in  = d;
        y_in  = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = 1'($urandom);
        d_in  = N'($urandom);
        y_in  = N'($urandom);
        lat    = 0;
        busyN  = 0;
        holdOk = 1'b1;
        for (int i = 1; i <= N + 4; i++) begin
            @(negedge clk);
            if (busy) begin
                busyN++;
                if (x_out !== lastX || cout !== lastC) holdOk = 1'b0;
            end
            if (done) begin
                lat = i;
                break;
            end
            op   = 1'($urandom);
            d_in = N'($urandom);
            y_in = N'($urandom);
        end
        gx = x_out;
        gc = cout;
    endtask

    task automatic applyStimulus(input string name, input logic o, input logic [N-1:0] d,
                                 input logic [N-1:0] y, input logic [N-1:0] ex, input logic ec);
        logic [N-1:0] gx;
        logic         gc;
        int           lat, busyN;
        bit           holdOk;
        runOp(o, d, y, gx, gc, lat, busyN, holdOk);
        checkOutput({name, " x_out"}, 32'(gx), 32'(ex));
        checkOutput({name, " cout"}, 32'(gc), 32'(ec));
        checkOutput({name, " latency"}, 32'(lat), 32'(N + 1));
        checkOutput({name, " busy cycles"}, 32'(busyN), 32'(N));
        checkOutput({name, " hold"}, 32'(holdOk), 32'(1));
        lastX = ex;
        lastC = ec;
    endtask

    initial begin
        vec_t table_v[5];
        logic [N-1:0] ex;
        logic         ec;
        int           doneCount, firstDone, secondDone, thirdDone;
        bit           sawDone;

        table_v[0] = '{1'b0, 4'b0101, 4'b0011, 4'b1000, 1'b0};
        table_v[1] = '{1'b0, 4'b1111, 4'b0001, 4'b0000, 1'b1};
        table_v[2] = '{1'b1, 4'b0010, 4'b0101, 4'b1101, 1'b1};
        table_v[3] = '{1'b1, 4'b1001, 4'b0011, 4'b0110, 1'b0};
        table_v[4] = '{1'b0, 4'b0110, 4'b0011, 4'b1001, 1'b0};

        #2 rst = 1'b1;
        #1;
        checkOutput("reset busy", 32'(busy), 32'(0));
        checkOutput("reset done", 32'(done), 32'(0));
        checkOutput("reset x_out", 32'(x_out), 32'(0));
        checkOutput("reset cout", 32'(cout), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            applyStimulus($sformatf("table[%0d]", i), table_v[i].op, table_v[i].d,
                          table_v[i].y, table_v[i].ex, table_v[i].ec);

        // Async reset mid-SHIFT after two bits; x_out currently holds 1001.
        @(negedge clk);
        start = 1'b1; op = 1'b0; d_in = 4'b0111; y_in = 4'b0111;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checkOutput("midreset busy", 32'(busy), 32'(0));
        checkOutput("midreset done", 32'(done), 32'(0));
        checkOutput("midreset x_out", 32'(x_out), 32'(0));
        checkOutput("midreset cout", 32'(cout), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        sawDone = 1'b0;
        for (int i = 0; i < N + 4; i++) begin
            @(negedge clk);
            if (done || busy) sawDone = 1'b1;
        end
        checkOutput("no done after reset", 32'(sawDone), 32'(0));
        lastX = '0;
        lastC = 1'b0;
        applyStimulus("post-reset sub", 1'b1, 4'b1001, 4'b0011, 4'b0110, 1'b0);

        // Exhaustive sweep of both modes against the arithmetic model.
        for (int o = 0; o < 2; o++)
            for (int d = 0; d < (1 << N); d++)
                for (int y = 0; y < (1 << N); y++) begin
                    model(1'(o), N'(d), N'(y), ex, ec);
                    applyStimulus($sformatf("sweep op=%0d d=%0d y=%0d", o, d, y),
                                  1'(o), N'(d), N'(y), ex, ec);
                end

        for (int i = 0; i < 40; i++) begin
            logic         ro;
            logic [N-1:0] rd, ry;
            ro = 1'($urandom);
            rd = N'($urandom);
            ry = N'($urandom);
            model(ro, rd, ry, ex, ec);
            applyStimulus($sformatf("random[%0d]", i), ro, rd, ry, ex, ec);
        end

        // start held high: one acceptance per N+2 cycles, extra starts ignored.
        @(negedge clk);
        start = 1'b1; op = 1'b0; d_in = 4'b0100; y_in = 4'b0101;
        doneCount = 0; firstDone = 0; secondDone = 0; thirdDone = 0;
        for (int i = 1; i <= 3 * (N + 2); i++) begin
            @(negedge clk);
            if (done) begin
                doneCount++;
                if (doneCount == 1) firstDone = i;
                else if (doneCount == 2) secondDone = i;
                else if (doneCount == 3) thirdDone = i;
            end
        end
        start = 1'b0;
        checkOutput("held start done count", 32'(doneCount), 32'(3));
        checkOutput("held start first done", 32'(firstDone), 32'(N + 1));
        checkOutput("held start period 1", 32'(secondDone - firstDone), 32'(N + 2));
        checkOutput("held start period 2", 32'(thirdDone - secondDone), 32'(N + 2));
        checkOutput("held start x_out", 32'(x_out), 32'(4'b1001));
        checkOutput("held start cout", 32'(cout), 32'(0));
        lastX = 4'b1001;
        lastC = 1'b0;
        applyStimulus("after held start", 1'b1, 4'b0000, 4'b0001, 4'b1111, 1'b1);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
